txn_order_fifo: RTL

Circular transaction tracker that holds each bus request from acceptance until retirement, using four LGFIFO-bit pointers: head, neck, torso and tail.
- head advances on write, neck on issue downstream, torso on response return, tail on retire upstream.
- The pointers are exported so the pointer-ordering property checker can be bound to this block.
- It sits between the upstream request port and the downstream slave.

---
 rtl/txn_order_fifo.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/txn_order_fifo.sv
`default_nettype none
// ============================================================================
// Module   : txn_order_fifo
// Purpose  : Circular transaction tracker between an upstream request port and
//            a downstream slave. Each request occupies one slot from acceptance
//            until it is retired. Four pointers walk the ring in order:
//              tail -> torso -> neck -> head
//            head advances on write, neck on issue downstream, torso on
//            response return, and tail on retire upstream. The pointers are
//            exported so an ordering-property checker can be bound here.
//            Optional build macro TXN_ORDER_FIFO_FILL_EN adds the registered
//            occupancy outputs o_fill and o_outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module txn_order_fifo #(
  parameter int LGFIFO = 4,
  parameter int DW     = 32,
  parameter int RW     = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [DW-1:0]     i_wr_data,
  output logic              o_full,
  output logic              o_iss_valid,
  output logic [DW-1:0]     o_iss_data,
  input  logic              i_iss_ready,
  input  logic              i_rsp,
  input  logic [RW-1:0]     i_rsp_data,
  output logic              o_rsp_err,
  output logic              o_ret_valid,
  output logic [DW-1:0]     o_ret_req,
  output logic [RW-1:0]     o_ret_rsp,
  input  logic              i_ret_ready,
  output logic [LGFIFO-1:0] o_head,
  output logic [LGFIFO-1:0] o_neck,
  output logic [LGFIFO-1:0] o_torso,
  output logic [LGFIFO-1:0] o_tail
`ifdef TXN_ORDER_FIFO_FILL_EN
  ,
  output logic [LGFIFO-1:0] o_fill,
  output logic [LGFIFO-1:0] o_outstanding
`endif
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO-1:0] PTR_ONE = LGFIFO'(1);

  // Ring pointers and their next-state values
  logic [LGFIFO-1:0] head_q, head_d;
  logic [LGFIFO-1:0] neck_q, neck_d;
  logic [LGFIFO-1:0] torso_q, torso_d;
  logic [LGFIFO-1:0] tail_q, tail_d;
  logic              rsp_err_q, rsp_err_d;

  // Slot storage; contents are meaningful only between the relevant pointers,
  // so no reset is applied to them.
  logic [DW-1:0] req_mem [DEPTH];
  logic [RW-1:0] rsp_mem [DEPTH];

  logic              full_w;
  logic              iss_valid_w;
  logic              outstanding_w;
  logic              ret_valid_w;
  logic              wr_fire_w;
  logic              iss_fire_w;
  logic              rsp_fire_w;
  logic              ret_fire_w;
  logic [LGFIFO-1:0] head_inc_w;

  // Status flags, derived only from the registered pointers (no bypass paths)
  always_comb begin
    head_inc_w    = head_q + PTR_ONE;
    full_w        = (head_inc_w == tail_q);
    iss_valid_w   = (neck_q != head_q);
    outstanding_w = (torso_q != neck_q);
    ret_valid_w   = (tail_q != torso_q);
  end

  // Stage handshakes and pointer next-state; every stage is judged against
  // the pre-edge pointers so simultaneous events never see each other.
  always_comb begin
    wr_fire_w  = i_wr && !full_w;
    iss_fire_w = iss_valid_w && i_iss_ready;
    rsp_fire_w = i_rsp && outstanding_w;
    ret_fire_w = ret_valid_w && i_ret_ready;

    head_d    = head_q;
    neck_d    = neck_q;
    torso_d   = torso_q;
    tail_d    = tail_q;
    rsp_err_d = i_rsp && !outstanding_w;

    if (wr_fire_w) begin
      head_d = head_inc_w;
    end
    if (iss_fire_w) begin
      neck_d = neck_q + PTR_ONE;
    end
    if (rsp_fire_w) begin
      torso_d = torso_q + PTR_ONE;
    end
    if (ret_fire_w) begin
      tail_d = tail_q + PTR_ONE;
    end
  end

  // Pointer and error-pulse registers; reset discards all in-flight entries
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_q    <= '0;
      neck_q    <= '0;
      torso_q   <= '0;
      tail_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      neck_q    <= neck_d;
      torso_q   <= torso_d;
      tail_q    <= tail_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Request payload capture at head, response payload capture at torso
  always_ff @(posedge i_clk) begin
    if (wr_fire_w) begin
      req_mem[head_q] <= i_wr_data;
    end
    if (rsp_fire_w) begin
      rsp_mem[torso_q] <= i_rsp_data;
    end
  end

`ifdef TXN_ORDER_FIFO_FILL_EN
  logic [LGFIFO-1:0] fill_q;
  logic [LGFIFO-1:0] outstanding_cnt_q;

  // Occupancy counters track the post-edge pointers exactly
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fill_q            <= '0;
      outstanding_cnt_q <= '0;
    end else begin
      fill_q            <= head_d - tail_d;
      outstanding_cnt_q <= neck_d - torso_d;
    end
  end

  assign o_fill        = fill_q;
  assign o_outstanding = outstanding_cnt_q;
`endif

  assign o_full      = full_w;
  assign o_iss_valid = iss_valid_w;
  assign o_iss_data  = req_mem[neck_q];
  assign o_rsp_err   = rsp_err_q;
  assign o_ret_valid = ret_valid_w;
  assign o_ret_req   = req_mem[tail_q];
  assign o_ret_rsp   = rsp_mem[tail_q];
  assign o_head      = head_q;
  assign o_neck      = neck_q;
  assign o_torso     = torso_q;
  assign o_tail      = tail_q;

endmodule
`default_nettype wire
